// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS field formats, widths, bit positions, opcodes and encoder FSM states
package mips_isa_pkg;

   typedef enum logic [1:0] {
      FMT_R   = 2'b00,
      FMT_I   = 2'b01,
      FMT_J   = 2'b10,
      FMT_ILL = 2'b11
   } fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int INSTR_W   = 32;
   localparam int OP_W      = 6;
   localparam int REG_W     = 5;
   localparam int SHAMT_W   = 5;
   localparam int FUNC_W    = 6;
   localparam int IMM_W     = 16;
   localparam int TGT_W     = 26;

   localparam int OP_LSB    = 26;
   localparam int RS_LSB    = 21;
   localparam int RT_LSB    = 16;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_LSB = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
   localparam logic [OP_W-1:0] OP_J     = 6'd2;
   localparam logic [OP_W-1:0] OP_JAL   = 6'd3;

   // Packs a field tuple into one instruction word; fields the format does not use are ignored.
   function automatic logic [INSTR_W-1:0] encode(
      input fmt_e                fmt,
      input logic [OP_W-1:0]     op,
      input logic [REG_W-1:0]    rs,
      input logic [REG_W-1:0]    rt,
      input logic [REG_W-1:0]    rd,
      input logic [SHAMT_W-1:0]  shamt,
      input logic [FUNC_W-1:0]   func,
      input logic [IMM_W-1:0]    imm16,
      input logic [TGT_W-1:0]    im26
   );
      logic [INSTR_W-1:0] w;
      w = INSTR_W'(op) << OP_LSB;
      if (fmt == FMT_J) begin
         w = w | INSTR_W'(im26);
      end else begin
         w = w | (INSTR_W'(rs) << RS_LSB) | (INSTR_W'(rt) << RT_LSB);
         w = (fmt == FMT_R)
           ? (w | (INSTR_W'(rd) << RD_LSB) | (INSTR_W'(shamt) << SHAMT_LSB) | INSTR_W'(func))
           : (w | INSTR_W'(imm16));
      end
      return w;
   endfunction

   // Opcode plausibility per format: R must be SPECIAL, J must be j/jal, I must be anything else.
   function automatic logic op_legal(input fmt_e fmt, input logic [OP_W-1:0] op);
      logic is_jump;
      is_jump = (op == OP_J) || (op == OP_JAL);
      return (fmt == FMT_R) ? (op == OP_RTYPE)
           : (fmt == FMT_J) ? is_jump
           : (fmt == FMT_I) ? !(is_jump || op == OP_RTYPE)
           : 1'b0;
   endfunction

endpackage

// File: rtl/instr_fifo2.sv
// instr_fifo2: 2-entry FIFO of {instr,addr} with valid/ready on both sides and registered head
module instr_fifo2 #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data
);

   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         push, pop;

   assign push_ready = (cnt_q != 2'd2);
   assign pop_valid  = (cnt_q != 2'd0);
   assign pop_data   = head_q;
   assign push       = push_valid && push_ready;
   assign pop        = pop_valid && pop_ready;

   // Head takes the tail on a pop from full, or new data when it would otherwise be empty.
   always_comb begin
      cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
      head_d = (pop && cnt_q == 2'd2) ? tail_q
             : (push && (cnt_q == 2'd0 || pop)) ? push_data
             : head_q;
      tail_d = (push && cnt_q == 2'd1 && !pop) ? push_data : tail_q;
   end

   // Storage and occupancy registers; reset empties the buffer and zeroes the visible head.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS field tuples into words streamed out with IM byte addresses (optional ENCODER_OPCHECK_EN)
module instr_encoder
   import mips_isa_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
   parameter int          DEPTH     = 1024,
   parameter int          CNT_W     = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_fmt,
   input  logic [5:0]       in_op,
   input  logic [4:0]       in_rs,
   input  logic [4:0]       in_rt,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_shamt,
   input  logic [5:0]       in_func,
   input  logic [15:0]      in_imm16,
   input  logic [25:0]      in_im26,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [31:0]      out_addr,
   output logic [CNT_W-1:0] word_count,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] word_count_q, word_count_d;
   logic             err_q, err_d;
   logic             accept, bad, push, push_ready;
   logic [63:0]      pop_data;

`ifdef ENCODER_OPCHECK_EN
   assign bad = (in_fmt == FMT_ILL) || !op_legal(fmt_e'(in_fmt), in_op);
`else
   assign bad = (in_fmt == FMT_ILL);
`endif

   assign in_ready   = (state_q == ST_RUN) && push_ready;
   assign accept     = in_valid && in_ready;
   assign push       = accept && !bad;
   assign word_count = word_count_q;
   assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done       = (state_q == ST_DONE);
   assign err        = err_q;
   assign out_instr  = pop_data[63:32];
   assign out_addr   = pop_data[31:0];

   instr_fifo2 #(.W(64)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (push),
      .push_ready (push_ready),
      .push_data  ({encode(fmt_e'(in_fmt), in_op, in_rs, in_rt, in_rd, in_shamt, in_func, in_imm16, in_im26), addr_q}),
      .pop_valid  (out_valid),
      .pop_ready  (out_ready),
      .pop_data   (pop_data)
   );

   // Run control: start opens a run, last tuple or a full IM closes intake, drain waits for the buffer.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      word_count_d = word_count_q;
      err_d        = err_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_RUN;
               addr_d       = BASE_ADDR;
               word_count_d = '0;
               err_d        = 1'b0;
            end
         end
         ST_RUN: begin
            if (accept) begin
               err_d        = err_q | bad;
               addr_d       = push ? addr_q + 32'd4 : addr_q;
               word_count_d = push ? word_count_q + CNT_W'(1) : word_count_q;
               state_d      = (in_last || (push && word_count_q == CNT_W'(DEPTH - 1))) ? ST_DRAIN : ST_RUN;
            end
         end
         default: state_d = out_valid ? ST_DRAIN : ST_DONE;
      endcase
   end

   // Control registers with synchronous reset to an idle, empty encoder.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         word_count_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         word_count_q <= word_count_d;
         err_q        <= err_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder (DEPTH=4 build)
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, in_ready, in_last, out_valid, out_ready;
   logic [1:0]  in_fmt;
   logic [5:0]  in_op, in_func;
   logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm16;
   logic [25:0] in_im26;
   logic [31:0] out_instr, out_addr;
   logic [2:0]  word_count;
   logic        busy, done, err;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb[$];
   bit          acc;

   always #5 clk = ~clk;

   instr_encoder #(.BASE_ADDR(32'h0000_3000), .DEPTH(4), .CNT_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_fmt     (in_fmt),
      .in_op      (in_op),
      .in_rs      (in_rs),
      .in_rt      (in_rt),
      .in_rd      (in_rd),
      .in_shamt   (in_shamt),
      .in_func    (in_func),
      .in_imm16   (in_imm16),
      .in_im26    (in_im26),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_addr   (out_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every completed output handshake is compared against the oldest expectation.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_word", {out_instr, out_addr}, 64'hx);
         end else begin
            logic [63:0] e;
            e = sb.pop_front();
            chk("out_instr", {32'd0, out_instr}, {32'd0, e[63:32]});
            chk("out_addr", {32'd0, out_addr}, {32'd0, e[31:0]});
         end
      end
   end

   task automatic offer(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tg, input logic last, input logic drop, input logic [31:0] ei,
                        input logic [31:0] ea, input int maxw, output bit a);
      in_fmt = f; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
      in_func = fn; in_imm16 = imm; in_im26 = tg; in_last = last; in_valid = 1'b1;
      a = 1'b0;
      for (int i = 0; i < maxw && !a; i++) begin
         @(negedge clk);
         if (in_ready) begin
            a = 1'b1;
            if (!drop) sb.push_back({ei, ea});
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tg, input logic last, input logic drop, input logic [31:0] ei,
                       input logic [31:0] ea);
      bit a;
      offer(f, op, rs, rt, rd, sh, fn, imm, tg, last, drop, ei, ea, 20, a);
      chk("accept", {63'd0, a}, 64'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && !done; i++) @(negedge clk);
      chk("done", {63'd0, done}, 64'd1);
      chk("busy_after_done", {63'd0, busy}, 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      in_fmt = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
      in_func = '0; in_imm16 = '0; in_im26 = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_outputs", {out_valid, in_ready, busy, done, err, word_count}, 64'd0);
      chk("rst_data", {out_instr, out_addr}, 64'd0);
      @(posedge clk);
      #1;

      // run 1: addu $3,$1,$2
      pulse_start();
      send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hFFFF, 26'h3FF_FFFF, 1'b1, 1'b0, 32'h0022_1821, 32'h3000);
      wait_done();
      chk("wc_run1", 64'(word_count), 64'd1);

      // run 2: ori $1,$0,0x1234 ; j 0x0C00 (unused fields deliberately non-zero)
      pulse_start();
      send(2'b01, 6'h0D, 5'd0, 5'd1, 5'd31, 5'd7, 6'h3F, 16'h1234, 26'h155_5555, 1'b0, 1'b0, 32'h3401_1234, 32'h3000);
      send(2'b10, 6'd2, 5'd9, 5'd9, 5'd9, 5'd9, 6'h2A, 16'hBEEF, 26'h000_0C00, 1'b1, 1'b0, 32'h0800_0C00, 32'h3004);
      wait_done();
      chk("wc_run2", 64'(word_count), 64'd2);

      // run 3: consumer stalled, buffer fills after two words
      out_ready = 1'b0;
      pulse_start();
      send(2'b01, 6'h23, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, 1'b0, 32'h8C22_0004, 32'h3000);
      send(2'b00, 6'd0, 5'd0, 5'd6, 5'd5, 5'd3, 6'h00, 16'd0, 26'd0, 1'b0, 1'b0, 32'h0006_28C0, 32'h3004);
      offer(2'b10, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1, 1'b0, 32'h0C00_0010, 32'h3008, 3, acc);
      chk("full_refuses", {63'd0, acc}, 64'd0);
      chk("full_out_valid", {63'd0, out_valid}, 64'd1);
      out_ready = 1'b1;
      send(2'b10, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1, 1'b0, 32'h0C00_0010, 32'h3008);
      wait_done();
      chk("wc_run3", 64'(word_count), 64'd3);

      // run 4: illegal format dropped mid-run
      pulse_start();
      chk("err_cleared_r4", {63'd0, err}, 64'd0);
      send(2'b00, 6'd0, 5'd1, 5'd2, 5'd4, 5'd0, 6'h21, 16'd0, 26'd0, 1'b0, 1'b0, 32'h0022_2021, 32'h3000);
      send(2'b11, 6'h0D, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h1111, 26'h1, 1'b0, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      chk("err_set", {63'd0, err}, 64'd1);
      chk("wc_excl_drop", 64'(word_count), 64'd1);
      @(posedge clk);
      #1;
      send(2'b01, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b1, 1'b0, 32'h3401_1234, 32'h3004);
      wait_done();
      chk("wc_run4", 64'(word_count), 64'd2);
      chk("err_sticky", {63'd0, err}, 64'd1);

      // run 5: DEPTH=4 reached without in_last; fifth tuple refused
      pulse_start();
      chk("err_cleared_r5", {63'd0, err}, 64'd0);
      for (int i = 1; i <= 4; i++)
         send(2'b10, 6'd2, 5'(i), 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'(i), 1'b0, 1'b0,
              32'h0800_0000 | 32'(i), 32'h3000 + 32'(4 * (i - 1)));
      offer(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd5, 1'b0, 1'b0, 32'h0800_0005, 32'h3010, 4, acc);
      chk("depth_refuses", {63'd0, acc}, 64'd0);
      wait_done();
      chk("wc_run5", 64'(word_count), 64'd4);

      // run 6: reset with two words buffered, then restart
      out_ready = 1'b0;
      pulse_start();
      send(2'b01, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, 1'b0, 32'h3401_1234, 32'h3000);
      send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0, 1'b0, 1'b0, 32'h0022_1821, 32'h3004);
      @(negedge clk);
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_state", {59'd0, out_valid, in_ready, busy, done, err}, 64'd0);
      chk("mid_rst_wc", 64'(word_count), 64'd0);
      sb.delete();
      @(posedge clk);
      #1 out_ready = 1'b1;
      pulse_start();
      send(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0C00, 1'b1, 1'b0, 32'h0800_0C00, 32'h3000);
      wait_done();
      chk("wc_run6", 64'(word_count), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
